// File: rtl/des_sbox_seq.sv
// Sequential DES S-box stage: captures one 48-bit word and evaluates LANES S-boxes per clock.
// Optional feature: define DES_SBOX_PARITY_EN to add the registered out_par parity output.
module des_sbox_seq #(
  parameter int LANES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  input  logic        flush
`ifdef DES_SBOX_PARITY_EN
  ,
  output logic        out_par
`endif
);

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8) begin : g_lanes_check
    $error("des_sbox_seq: LANES must be 1, 2, 4 or 8");
  end

  localparam logic [2:0] STEP     = 3'(LANES);
  localparam logic [2:0] LAST_CNT = 3'(8 - LANES);

  // NOTE: the S-box tables are constants, so they become logic with no storage to reset.
  localparam logic [3:0] SBOX [8][64] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
       0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
      15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
       3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
      13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
       1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
      13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
       3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
      14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
      11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
      10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
       4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
      13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
       6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
       1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
       2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}
  };

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      r_state;
  logic [2:0]  r_cnt;
  logic [47:0] r_data;
  logic [31:0] r_result;
  logic        r_in_ready;
  logic        r_out_valid;
  logic [31:0] w_next;
  logic        w_last;

  // Replace nibble idx of res with S(idx+1) applied to chunk idx of din (idx 0 is S1, the MSBs).
  function automatic logic [31:0] apply_lane(input logic [31:0] res, input logic [47:0] din,
                                             input logic [2:0] idx);
    logic [5:0]  c;
    logic [31:0] r;
    c = 6'(din >> (6'd42 - 6'(idx) * 6'd6));
    r = res;
    r[5'd31 - {idx, 2'b00} -: 4] = SBOX[idx][{c[5], c[0], c[4:1]}];
    return r;
  endfunction

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_next = r_result;
    for (int l = 0; l < LANES; l++) begin
      w_next = apply_lane(w_next, r_data, r_cnt + 3'(l));
    end
  end

  assign w_last = (r_cnt == LAST_CNT);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_data      <= '0;
      r_result    <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else if (flush) begin
      // out_data is deliberately kept; only the handshake state is abandoned.
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_data     <= in_data;
          r_cnt      <= '0;
          r_result   <= '0;
          r_in_ready <= 1'b0;
          r_state    <= RUN;
        end
        RUN: begin
          r_result <= w_next;
          r_cnt    <= r_cnt + STEP;
          if (w_last) begin
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_result;

`ifdef DES_SBOX_PARITY_EN
  logic r_par;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par <= 1'b0;
    end else if (!flush && r_state == RUN && w_last) begin
      r_par <= ^w_next;
    end
  end

  assign out_par = r_par;
`endif

endmodule

// File: tb/tb_des_sbox_seq.sv
// Directed bench for des_sbox_seq: three instances (LANES = 2, 8, 1) driven from vector tables.
module tb_des_sbox_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv   [3];
  logic [47:0] id   [3];
  logic        ordy [3];
  logic        fl   [3];
  logic        ir   [3];
  logic        ov   [3];
  logic [31:0] od   [3];
`ifdef DES_SBOX_PARITY_EN
  logic        op   [3];
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  des_sbox_seq #(.LANES(2)) u_dut_l2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .flush(fl[0])
`ifdef DES_SBOX_PARITY_EN
    , .out_par(op[0])
`endif
  );

  des_sbox_seq #(.LANES(8)) u_dut_l8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .flush(fl[1])
`ifdef DES_SBOX_PARITY_EN
    , .out_par(op[1])
`endif
  );

  des_sbox_seq #(.LANES(1)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]), .flush(fl[2])
`ifdef DES_SBOX_PARITY_EN
    , .out_par(op[2])
`endif
  );

  // FIPS 46-3 reference tables, [box][row][column].
  int SB [8][4][16] = '{
    '{'{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7}, '{0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8},
      '{4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0}, '{15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13}},
    '{'{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10}, '{3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5},
      '{0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15}, '{13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9}},
    '{'{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8}, '{13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1},
      '{13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7}, '{1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12}},
    '{'{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15}, '{13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9},
      '{10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4}, '{3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14}},
    '{'{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9}, '{14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6},
      '{4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14}, '{11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3}},
    '{'{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11}, '{10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8},
      '{9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6}, '{4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13}},
    '{'{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1}, '{13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6},
      '{1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2}, '{6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12}},
    '{'{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7}, '{1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2},
      '{7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8}, '{2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}}
  };

  typedef struct {
    int          dut;   // 0: LANES=2, 1: LANES=8, 2: LANES=1
    logic [47:0] din;
    logic [31:0] exp;
    int          lat;
    int          hold;  // extra DONE cycles with out_ready low
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic run_word(input int d, input logic [47:0] din, input logic [31:0] exp,
                          input int lat, input int hold, input string name);
    int cyc;
    check({name, " ready"}, 32'(ir[d]), 32'd1);
    @(negedge clk);
    iv[d] = 1'b1;
    id[d] = din;
    @(posedge clk);
    #1;
    iv[d] = 1'b0;
    check({name, " busy"}, {30'd0, ir[d], ov[d]}, 32'd0);
    cyc = 0;
    while (!ov[d] && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({name, " latency"}, 32'(cyc), 32'(lat));
    check({name, " data"}, od[d], exp);
`ifdef DES_SBOX_PARITY_EN
    check({name, " parity"}, 32'(op[d]), 32'(^exp));
`endif
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check($sformatf("%s hold%0d valid/ready", name, h), {30'd0, ov[d], ir[d]}, 32'd2);
      check($sformatf("%s hold%0d data", name, h), od[d], exp);
    end
    @(negedge clk);
    ordy[d] = 1'b1;
    @(posedge clk);
    #1;
    ordy[d] = 1'b0;
    check({name, " released"}, {30'd0, ov[d], ir[d]}, 32'd1);
  endtask

  initial begin
    logic [31:0] exp;
    logic [47:0] din;
    logic [5:0]  vv;
    bit          seen;

    vecs[0] = '{0, 48'h000000000000, 32'hEFA72C4D, 4, 0};
    vecs[1] = '{1, 48'hFFFFFFFFFFFF, 32'hD9CE3DCB, 1, 0};
    vecs[2] = '{2, 48'h000000000000, 32'hEFA72C4D, 8, 5};
    vecs[3] = '{0, 48'hFFFFFFFFFFFF, 32'hD9CE3DCB, 4, 0};
    vecs[4] = '{0, 48'h041041041041, 32'h03DDEAD1, 4, 0};
    vecs[5] = '{0, 48'h820820820820, 32'h40DA4917, 4, 2};
    vecs[6] = '{0, 48'h79E79E79E79E, 32'h7A8F9B17, 4, 0};
    vecs[7] = '{1, 48'h041041041041, 32'h03DDEAD1, 1, 0};
    vecs[8] = '{2, 48'h820820820820, 32'h40DA4917, 8, 0};
    vecs[9] = '{1, 48'h79E79E79E79E, 32'h7A8F9B17, 1, 1};

    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0; id[d] = '0; ordy[d] = 1'b0; fl[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset dut%0d ready/valid", d), {30'd0, ir[d], ov[d]}, 32'd2);
      check($sformatf("reset dut%0d data", d), od[d], 32'd0);
`ifdef DES_SBOX_PARITY_EN
      check($sformatf("reset dut%0d parity", d), 32'(op[d]), 32'd0);
`endif
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_word(vecs[i].dut, vecs[i].din, vecs[i].exp, vecs[i].lat, vecs[i].hold,
               $sformatf("vec%0d", i));
    end

    // Flush in the second RUN cycle of the LANES=1 instance.
    check("flush ready", 32'(ir[2]), 32'd1);
    @(negedge clk);
    iv[2] = 1'b1;
    id[2] = 48'hFFFFFFFFFFFF;
    @(posedge clk);
    #1;
    iv[2] = 1'b0;
    @(posedge clk);
    #1;
    fl[2] = 1'b1;
    @(posedge clk);
    #1;
    fl[2] = 1'b0;
    check("flush idle", {30'd0, ir[2], ov[2]}, 32'd2);
    check("flush keeps data", od[2], 32'hD0000000);
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (ov[2]) seen = 1'b1;
    end
    check("flush no valid", 32'(seen), 32'd0);
    run_word(2, 48'h000000000000, 32'hEFA72C4D, 8, 0, "post-flush");

    // Asynchronous reset pulse mid-RUN on the LANES=2 instance.
    @(negedge clk);
    iv[0] = 1'b1;
    id[0] = 48'hFFFFFFFFFFFF;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async reset ready/valid", {30'd0, ir[0], ov[0]}, 32'd2);
    check("async reset data", od[0], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("after reset no valid", {30'd0, ir[0], ov[0]}, 32'd2);

    // Each chunk swept over all 64 values with the other chunks held at zero.
    for (int k = 0; k < 8; k++) begin
      for (int v = 0; v < 64; v++) begin
        vv  = 6'(v);
        din = '0;
        din[47 - 6*k -: 6] = vv;
        exp = 32'hEFA72C4D;
        exp[31 - 4*k -: 4] = 4'(SB[k][{vv[5], vv[0]}][vv[4:1]]);
        run_word(0, din, exp, 4, 0, $sformatf("sweep S%0d v%0d", k + 1, v));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
